pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Hazard and sequencing controller for the five-stage pipeline. It decides every cycle whether each inter-stage pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) captures, holds (stall) or loads a bubble (flush). Events handled: load-use hazards, EX-stage branch redirects, MEM-stage exceptions, instruction/data memory wait states and multi-cycle multiply/divide occupancy of EX. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MUL_CYCLES, 3: EX occupancy of a multiply, in cycles (≥1)
- DIV_CYCLES, 32: EX occupancy of a divide, in cycles (≥1)
- CNT_W, 6: occupancy counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  clock, all state updates on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_rs, id_rt  in  5  source register numbers of the instruction in ID
- id_use_rs, id_use_rt  in  1  ID instruction actually reads rs / rt
- ex_load  in  1  EX instruction is a load
- ex_rd  in  5  EX destination register
- ex_redirect  in  1  branch/jump in EX resolved taken
- ex_md_start  in  1  EX instruction is mul/div
- ex_md_div  in  1  1 = divide, 0 = multiply (valid with ex_md_start)
- mem_exc  in  1  MEM instruction raises an exception
- imem_ready  in  1  instruction fetch completes this cycle
- dmem_ready  in  1  data access of the MEM instruction completes this cycle (tie 1 when MEM has no access)
- stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb  out  1  hold the register
- flush_if_id, flush_id_ex, flush_ex_mem  out  1  load a bubble (wins over stall in that register)
- md_busy  out  1  mul/div occupies EX
- md_done  out  1  one-cycle pulse, last cycle of mul/div
- perf_stalls  out  32  count of cycles with stall_pc=1, saturating

## Operation
- FSM states: RUN, MD. Occupancy counter cnt (CNT_W bits).
- Conditions, evaluated combinationally, highest priority first:
  - EXC = mem_exc: flush_if_id, flush_id_ex, flush_ex_mem; nothing stalled; FSM → RUN, cnt → 0 (mul/div aborted, no md_done).
  - DWAIT = !dmem_ready: all five stall_* = 1, no flush. FSM and cnt frozen.
  - MDS = (RUN & ex_md_start) | MD, unless the MD counter-zero cycle: stall_pc, stall_if_id, stall_id_ex; flush_ex_mem.
  - RED = ex_redirect: flush_if_id, flush_id_ex; PC loads target (stall_pc=0).
  - LU = ex_load & ex_rd≠0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)): stall_pc, stall_if_id; flush_id_ex.
  - IWAIT = !imem_ready: stall_pc; flush_if_id.
- Only the highest active condition drives the outputs; RED suppresses LU and IWAIT.
- ex_md_start and ex_redirect are ignored while in MD.
- MD entry: RUN & ex_md_start & !EXC & !DWAIT → cnt ← N−1 (N = DIV_CYCLES if ex_md_div, else MUL_CYCLES), next state MD.
- In MD, without DWAIT: if cnt≠0, decrement; if cnt==0, md_done=1, no MD stall, state → RUN.
- md_busy = MDS active.
- perf_stalls increments on every cycle with stall_pc=1 and holds at 0xFFFF_FFFF.

## Timing
- While rst_n=0: state RUN, cnt=0, perf_stalls=0, all stall/flush/md outputs 0.
- All outputs are combinational from state and inputs; no added pipeline latency.
- Mul/div with start at cycle T: stall active for exactly N cycles (T…T+N−1). md_done is high at T+N. The instruction leaves EX at the T+N edge. Each DWAIT cycle inside this window extends it by one.
- N=1: MD lasts a single cycle, with cnt=0 and md_done.
- Load-use stalls exactly one cycle; the next cycle the load is in MEM and LU is false.
- Asynchronous reset mid-MD returns to RUN immediately.

## Structure
- Shared pipeline package: stage-index constants, register-number width (5), and FSM state encoding.
- A single sub-module, md_occ_counter (load/decrement/freeze/clear, zero flag), is natural. Everything else is flat.

## Test plan
- ID reads $3 via rs, EX is a load to $3 → stall_pc=stall_if_id=flush_id_ex=1 for 1 cycle. Same case with ex_rd=$0 → no stall.
- ex_md_start, ex_md_div=1, DIV_CYCLES=32 → md_busy and flush_ex_mem for 32 cycles, md_done on cycle 33. With MUL_CYCLES=3 → 3 stall cycles.
- dmem_ready=0 for 2 cycles in the middle of a divide → all stalls high, total MD window 34 cycles, md_done exactly once.
- mem_exc in MD cycle 5 → three flushes, md_busy drops next cycle, no md_done.
- ex_redirect with LU and imem_ready=0 in the same cycle → only flush_if_id and flush_id_ex, stall_pc=0.
- Hold imem_ready=0 → perf_stalls counts every cycle. Preload near the maximum → saturates at 0xFFFF_FFFF. Asserting rst_n low clears it.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared pipeline constants and controller state encoding
package pipe_ctrl_pkg;

  localparam int REG_W = 5;

  localparam int STG_PC     = 0;
  localparam int STG_IF_ID  = 1;
  localparam int STG_ID_EX  = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_MEM_WB = 4;
  localparam int NUM_STG    = 5;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MD  = 1'b1
  } md_state_e;

endpackage

// File: rtl/pipe_ctrl_md_occ_counter.sv
// rtl/pipe_ctrl_md_occ_counter.sv - mul/div EX occupancy counter with zero flag
module md_occ_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear beats load beats decrement; with none asserted the count is frozen.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard, stall/flush and mul/div sequencing controller
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_redirect,
  input  logic             ex_md_start,
  input  logic             ex_md_div,
  input  logic             mem_exc,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             stall_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             md_busy,
  output logic             md_done,
  output logic [31:0]      perf_stalls
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [31:0]      perf_q, perf_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero, cnt_clr, cnt_load, cnt_dec;
  logic [CNT_W-1:0] cnt_load_val;

  logic               in_md, md_stall, red, lu;
  logic [NUM_STG-1:0] stall_v;
  logic               fl_if_id, fl_id_ex, fl_ex_mem, done;

  assign in_md    = (state_q == ST_MD);
  // The counter-zero cycle of MD releases the pipeline instead of stalling it.
  assign md_stall = (!in_md && ex_md_start) || (in_md && !cnt_zero);
  assign red      = !in_md && ex_redirect;
  assign lu       = ex_load && (ex_rd != '0) &&
                    ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));

  always_comb begin
    stall_v      = '0;
    fl_if_id     = 1'b0;
    fl_id_ex     = 1'b0;
    fl_ex_mem    = 1'b0;
    done         = 1'b0;
    state_d      = state_q;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = ex_md_div ? DIV_LOAD : MUL_LOAD;
    if (rst_n) begin
      if (mem_exc) begin
        fl_if_id  = 1'b1;
        fl_id_ex  = 1'b1;
        fl_ex_mem = 1'b1;
        state_d   = ST_RUN;
        cnt_clr   = 1'b1;
      end else if (!dmem_ready) begin
        stall_v = '1;
      end else begin
        if (md_stall) begin
          stall_v[STG_PC]    = 1'b1;
          stall_v[STG_IF_ID] = 1'b1;
          stall_v[STG_ID_EX] = 1'b1;
          fl_ex_mem          = 1'b1;
        end else if (red) begin
          fl_if_id = 1'b1;
          fl_id_ex = 1'b1;
        end else if (lu) begin
          stall_v[STG_PC]    = 1'b1;
          stall_v[STG_IF_ID] = 1'b1;
          fl_id_ex           = 1'b1;
        end else if (!imem_ready) begin
          stall_v[STG_PC] = 1'b1;
          fl_if_id        = 1'b1;
        end

        if (!in_md) begin
          if (ex_md_start) begin
            cnt_load = 1'b1;
            state_d  = ST_MD;
          end
        end else if (cnt_zero) begin
          done    = 1'b1;
          state_d = ST_RUN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
    end
  end

  md_occ_counter #(
    .CNT_W (CNT_W)
  ) u_md_occ_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  assign perf_d = (stall_v[STG_PC] && perf_q != 32'hFFFF_FFFF) ? perf_q + 32'd1 : perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      perf_q  <= perf_d;
    end
  end

  assign stall_pc     = stall_v[STG_PC];
  assign stall_if_id  = stall_v[STG_IF_ID];
  assign stall_id_ex  = stall_v[STG_ID_EX];
  assign stall_ex_mem = stall_v[STG_EX_MEM];
  assign stall_mem_wb = stall_v[STG_MEM_WB];
  assign flush_if_id  = fl_if_id;
  assign flush_id_ex  = fl_id_ex;
  assign flush_ex_mem = fl_ex_mem;
  assign md_busy      = rst_n && md_stall;
  assign md_done      = done;
  assign perf_stalls  = perf_q;

  // cnt is only consumed through the zero flag; keep the full value observable.
  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl against a cycle-level reference model
module tb_pipe_ctrl;

  localparam int MUL_N = 3;
  localparam int DIV_N = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_use_rs, id_use_rt, ex_load, ex_redirect, ex_md_start, ex_md_div;
  logic        mem_exc, imem_ready, dmem_ready;
  logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic        flush_if_id, flush_id_ex, flush_ex_mem, md_busy, md_done;
  logic [31:0] perf_stalls;

  pipe_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_load(ex_load), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .ex_md_start(ex_md_start), .ex_md_div(ex_md_div), .mem_exc(mem_exc),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .stall_pc(stall_pc),
    .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex), .stall_ex_mem(stall_ex_mem),
    .stall_mem_wb(stall_mem_wb), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .flush_ex_mem(flush_ex_mem), .md_busy(md_busy), .md_done(md_done),
    .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt, rd;
    logic use_rs, use_rt, load, redirect, md_start, md_div, exc, imem, dmem;
  } stim_t;

  // stall bits: [0]=pc [1]=if_id [2]=id_ex [3]=ex_mem [4]=mem_wb; flush bits: [0]=if_id [1]=id_ex [2]=ex_mem
  typedef struct {
    logic [4:0]  stall;
    logic [2:0]  flush;
    logic        busy, done;
    logic [31:0] perf;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          busy_left;   // busy cycles still owed by the current mul/div
  bit          done_due;    // the next non-waiting cycle is the mul/div release cycle
  logic [31:0] m_perf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rs: 5'd0, rt: 5'd0, rd: 5'd0, use_rs: 1'b0, use_rt: 1'b0, load: 1'b0,
          redirect: 1'b0, md_start: 1'b0, md_div: 1'b0, exc: 1'b0, imem: 1'b1, dmem: 1'b1};
    return s;
  endfunction

  task automatic apply(input stim_t s);
    id_rs = s.rs; id_rt = s.rt; ex_rd = s.rd; id_use_rs = s.use_rs; id_use_rt = s.use_rt;
    ex_load = s.load; ex_redirect = s.redirect; ex_md_start = s.md_start; ex_md_div = s.md_div;
    mem_exc = s.exc; imem_ready = s.imem; dmem_ready = s.dmem;
  endtask

  task automatic model_reset();
    busy_left = 0;
    done_due  = 1'b0;
    m_perf    = '0;
  endtask

  task automatic run_cycle(input stim_t s);
    exp_t e;
    bit   in_md, busy_now, hazard;
    @(negedge clk);
    #1;
    apply(s);
    in_md    = (busy_left > 0) || done_due;
    busy_now = (busy_left > 0) || (!in_md && s.md_start);
    hazard   = s.load && s.rd != 5'd0 &&
               ((s.use_rs && s.rs == s.rd) || (s.use_rt && s.rt == s.rd));
    e.stall = 5'b0; e.flush = 3'b0;
    e.busy  = busy_now;
    e.done  = done_due && !s.exc && s.dmem;
    e.perf  = m_perf;
    if (s.exc)                     e.flush = 3'b111;
    else if (!s.dmem)              e.stall = 5'b11111;
    else if (busy_now)             begin e.stall = 5'b00111; e.flush = 3'b100; end
    else if (!in_md && s.redirect) e.flush = 3'b011;
    else if (hazard)               begin e.stall = 5'b00011; e.flush = 3'b010; end
    else if (!s.imem)              begin e.stall = 5'b00001; e.flush = 3'b001; end
    exp_q.push_back(e);
    if (s.exc) begin
      busy_left = 0;
      done_due  = 1'b0;
    end else if (s.dmem) begin
      if (busy_now) begin
        busy_left = ((busy_left > 0) ? busy_left : (s.md_div ? DIV_N : MUL_N)) - 1;
        done_due  = (busy_left == 0);
      end else if (done_due) begin
        done_due = 1'b0;
      end
    end
    if (e.stall[0] && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stalls"}, {27'd0, stall_mem_wb, stall_ex_mem, stall_id_ex, stall_if_id, stall_pc}, 32'd0);
    check({tag, "_flushes"}, {29'd0, flush_ex_mem, flush_id_ex, flush_if_id}, 32'd0);
    check({tag, "_md"}, {30'd0, md_busy, md_done}, 32'd0);
    check({tag, "_perf"}, perf_stalls, 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall_vec", {27'd0, stall_mem_wb, stall_ex_mem, stall_id_ex, stall_if_id, stall_pc},
              {27'd0, e.stall});
        check("flush_vec", {29'd0, flush_ex_mem, flush_id_ex, flush_if_id}, {29'd0, e.flush});
        check("md_busy", {31'd0, md_busy}, {31'd0, e.busy});
        check("md_done", {31'd0, md_done}, {31'd0, e.done});
        check("perf_stalls", perf_stalls, e.perf);
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    rst_n = 1'b0;
    s = idle(); s.dmem = 1'b0; s.imem = 1'b0; s.md_start = 1'b1;
    apply(s);
    model_reset();
    #2 check_all_zero("reset");
    repeat (2) @(negedge clk);
    check_all_zero("reset_held");
    apply(idle());
    rst_n = 1'b1;

    // load-use via rs, then same with $0, then via rt
    s = idle(); s.load = 1'b1; s.rd = 5'd3; s.rs = 5'd3; s.use_rs = 1'b1;
    run_cycle(s); run_cycle(idle());
    s.rd = 5'd0; s.rs = 5'd0; run_cycle(s);
    s = idle(); s.load = 1'b1; s.rd = 5'd5; s.rt = 5'd5; s.use_rt = 1'b1; s.rs = 5'd5;
    run_cycle(s); run_cycle(idle());

    // divide, then multiply
    s = idle(); s.md_start = 1'b1; s.md_div = 1'b1;
    run_cycle(s); repeat (34) run_cycle(idle());
    s.md_div = 1'b0;
    run_cycle(s); repeat (5) run_cycle(idle());

    // divide with two data-memory wait cycles mid-window
    s = idle(); s.md_start = 1'b1; s.md_div = 1'b1;
    run_cycle(s); repeat (8) run_cycle(idle());
    s = idle(); s.dmem = 1'b0; run_cycle(s); run_cycle(s);
    repeat (26) run_cycle(idle());

    // exception in the fifth mul/div cycle
    s = idle(); s.md_start = 1'b1; s.md_div = 1'b1;
    run_cycle(s); repeat (3) run_cycle(idle());
    s = idle(); s.exc = 1'b1; run_cycle(s);
    repeat (3) run_cycle(idle());

    // redirect beats load-use and fetch wait
    s = idle(); s.redirect = 1'b1; s.imem = 1'b0; s.load = 1'b1; s.rd = 5'd7; s.rs = 5'd7; s.use_rs = 1'b1;
    run_cycle(s); run_cycle(idle());

    // sustained fetch wait
    s = idle(); s.imem = 1'b0;
    repeat (6) run_cycle(s);
    run_cycle(idle());

    // asynchronous reset in the middle of a divide
    s = idle(); s.md_start = 1'b1; s.md_div = 1'b1;
    run_cycle(s); repeat (5) run_cycle(idle());
    @(negedge clk); #5;
    rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    apply(idle());
    @(negedge clk); rst_n = 1'b1;
    run_cycle(idle());

    // saturation of the stall counter from a preloaded value
    @(negedge clk); #5;
    force dut.perf_q = 32'hFFFF_FFFC;
    #1 release dut.perf_q;
    m_perf = 32'hFFFF_FFFC;
    s = idle(); s.imem = 1'b0;
    repeat (7) run_cycle(s);
    @(negedge clk); #5;
    rst_n = 1'b0;
    #1 check_all_zero("perf_clear");
    model_reset();
    apply(idle());
    @(negedge clk); rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s.rs       = 5'($urandom_range(0, 3));
      s.rt       = 5'($urandom_range(0, 3));
      s.rd       = 5'($urandom_range(0, 3));
      s.use_rs   = 1'($urandom_range(0, 1));
      s.use_rt   = 1'($urandom_range(0, 1));
      s.load     = ($urandom_range(0, 2) == 0);
      s.redirect = ($urandom_range(0, 7) == 0);
      s.md_start = ($urandom_range(0, 11) == 0);
      s.md_div   = ($urandom_range(0, 2) == 0);
      s.exc      = ($urandom_range(0, 49) == 0);
      s.imem     = ($urandom_range(0, 4) != 0);
      s.dmem     = ($urandom_range(0, 7) != 0);
      run_cycle(s);
    end

    repeat (2) @(negedge clk);
    #5;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
